// File: rtl/bank_rotate_ctrl.sv
// Round-robin bank sequencer between the DRAM loader and the PE array.
// Tracks per-bank full flags and drives the router bank select and beat address.
module bank_rotate_ctrl #(
  parameter int unsigned POY = 3,
  parameter int unsigned LW  = 8,
  parameter int unsigned TW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LW-1:0]  cfg_len,
  input  logic [TW-1:0]  cfg_tiles,
  output logic           busy,
  output logic           done,
  output logic [1:0]     wr_bank,
  output logic           wr_ready,
  input  logic           wr_done,
  output logic [1:0]     rd_bank,
  output logic [LW-1:0]  rd_addr,
  output logic           rd_valid,
  input  logic           rd_ready,
  output logic           rd_last,
  output logic [POY-1:0] full_mask,
  output logic           err
);

  localparam logic [1:0] LAST_BANK = 2'(POY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  rd_addr_q, rd_addr_d;
  logic [TW-1:0]  tiles_q, tiles_d;
  logic [TW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [TW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [1:0]     wr_bank_q, wr_bank_d;
  logic [1:0]     rd_bank_q, rd_bank_d;
  logic [POY-1:0] full_q, full_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           run;
  logic           wr_fire;
  logic           rd_fire;

  function automatic logic [1:0] next_bank(input logic [1:0] b);
    return (b == LAST_BANK) ? 2'd0 : b + 2'd1;
  endfunction

  assign run = (state_q == ST_RUN);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= LW'(1);
      tiles_q   <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 2'd0;
      rd_bank_q <= 2'd0;
      rd_addr_q <= '0;
      full_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      tiles_q   <= tiles_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_addr_q <= rd_addr_d;
      full_q    <= full_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; fill and drain may land in the same cycle on different banks
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    tiles_d   = tiles_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    full_d    = full_q;
    err_d     = err_q;

    wr_ready = run & ~full_q[wr_bank_q] & (wr_cnt_q < tiles_q);
    rd_valid = run & full_q[rd_bank_q];
    rd_last  = rd_valid & (rd_addr_q == (len_q - LW'(1)));
    wr_fire  = wr_done & wr_ready;
    rd_fire  = rd_valid & rd_ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d     = (cfg_len == '0) ? LW'(1) : cfg_len;
          tiles_d   = cfg_tiles;
          wr_cnt_d  = '0;
          rd_cnt_d  = '0;
          wr_bank_d = 2'd0;
          rd_bank_d = 2'd0;
          rd_addr_d = '0;
          full_d    = '0;
          state_d   = (cfg_tiles == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (wr_fire) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = next_bank(wr_bank_q);
          wr_cnt_d          = wr_cnt_q + TW'(1);
        end
        if (rd_fire) begin
          if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_addr_d         = '0;
            rd_bank_d         = next_bank(rd_bank_q);
            rd_cnt_d          = rd_cnt_q + TW'(1);
          end else begin
            rd_addr_d = rd_addr_q + LW'(1);
          end
        end
        if (rd_cnt_d == tiles_q) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wr_done && !wr_ready) begin
      err_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_bank   = wr_bank_q;
  assign rd_bank   = rd_bank_q;
  assign rd_addr   = rd_addr_q;
  assign full_mask = full_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bank_rotate_ctrl.sv
// Randomized and directed bench for bank_rotate_ctrl, checked cycle by cycle
// against a FIFO-of-banks reference model.
module tb_bank_rotate_ctrl;

  localparam int unsigned POY = 3;
  localparam int unsigned LW  = 8;
  localparam int unsigned TW  = 16;
  localparam int unsigned OW  = 1 + 1 + 2 + 1 + 2 + LW + 1 + 1 + POY + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [LW-1:0]  cfg_len;
  logic [TW-1:0]  cfg_tiles;
  logic           busy;
  logic           done;
  logic [1:0]     wr_bank;
  logic           wr_ready;
  logic           wr_done;
  logic [1:0]     rd_bank;
  logic [LW-1:0]  rd_addr;
  logic           rd_valid;
  logic           rd_ready;
  logic           rd_last;
  logic [POY-1:0] full_mask;
  logic           err;

  bank_rotate_ctrl #(.POY(POY), .LW(LW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_tiles(cfg_tiles),
    .busy(busy), .done(done), .wr_bank(wr_bank), .wr_ready(wr_ready),
    .wr_done(wr_done), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .full_mask(full_mask), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: layer phase (0 idle, 1 run, 2 fin), counters, and a FIFO of filled banks
  int m_phase, m_len, m_tiles, m_wcnt, m_rcnt, m_addr;
  bit m_err;
  int m_q[$];

  // Observations of the DUT's own handshakes
  int d_hs;
  int d_drain[$];
  int d_fill[$];

  function automatic bit m_wr_ready();
    return (m_phase == 1) && (m_q.size() < POY) && (m_wcnt < m_tiles);
  endfunction

  function automatic bit m_rd_valid();
    return (m_phase == 1) && (m_q.size() > 0);
  endfunction

  function automatic bit m_rd_last();
    return m_rd_valid() && (m_addr == m_len - 1);
  endfunction

  function automatic logic [POY-1:0] m_mask();
    logic [POY-1:0] m   = '0;
    logic [POY-1:0] one = POY'(1);
    foreach (m_q[i]) m = m | (one << m_q[i]);
    return m;
  endfunction

  function automatic logic [OW-1:0] expv();
    return {m_phase != 0, m_phase == 2, 2'(m_wcnt % POY), m_wr_ready(),
            2'(m_rcnt % POY), LW'(m_addr), m_rd_valid(), m_rd_last(), m_mask(), m_err};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {busy, done, wr_bank, wr_ready, rd_bank, rd_addr, rd_valid, rd_last, full_mask, err};
  endfunction

  task automatic m_reset();
    m_phase = 0; m_len = 1; m_tiles = 0; m_wcnt = 0; m_rcnt = 0; m_addr = 0;
    m_err = 1'b0;
    m_q.delete();
  endtask

  // One clock: drive inputs, record DUT handshakes, advance the model
  task automatic step(input bit s, input int len, input int tiles, input bit wd, input bit rr);
    bit wrr, rv, rl;
    wrr = m_wr_ready();
    rv  = m_rd_valid();
    rl  = m_rd_last();
    start = s; cfg_len = LW'(len); cfg_tiles = TW'(tiles); wr_done = wd; rd_ready = rr;
    #1;
    if (rd_valid && rr) d_hs++;
    if (rd_valid && rr && rd_last) d_drain.push_back(int'(rd_bank));
    if (wr_ready && wd) d_fill.push_back(int'(wr_bank));
    @(posedge clk);
    #1;
    if (m_phase == 0) begin
      if (s) begin
        m_len = (len == 0) ? 1 : len;
        m_tiles = tiles;
        m_wcnt = 0; m_rcnt = 0; m_addr = 0;
        m_q.delete();
        m_phase = (tiles == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      if (rv && rr) begin
        if (rl) begin
          void'(m_q.pop_front());
          m_rcnt++;
          m_addr = 0;
        end else begin
          m_addr++;
        end
      end
      if (wd && wrr) begin
        m_q.push_back(m_wcnt % POY);
        m_wcnt++;
      end
      if (m_rcnt == m_tiles) m_phase = 2;
    end else begin
      m_phase = 0;
    end
    if (wd && !wrr) m_err = 1'b1;
    start = 1'b0;
    wr_done = 1'b0;
  endtask

  task automatic clear_obs();
    d_hs = 0;
    d_drain.delete();
    d_fill.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_tiles = '0; wr_done = 1'b0; rd_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== OW'(0)) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", obs(), OW'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_basic();
    bit seen = 1'b0;
    int hs_at_done = -1;
    bit ok;
    clear_obs();
    step(1'b1, 4, 3, 1'b0, 1'b1);
    for (int c = 0; c < 100 && !seen; c++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL basic_cyc%0d got=%h exp=%h", c, obs(), expv());
      end
      if (done) begin seen = 1'b1; hs_at_done = d_hs; end
      if (!seen) step(1'b0, 4, 3, m_wr_ready(), 1'b1);
    end
    checks++;
    if (!seen || hs_at_done !== 12) begin
      errors++; $display("FAIL basic_done seen=%0d handshakes=%0d exp=12", seen, hs_at_done);
    end
    ok = (d_drain.size() == 3);
    foreach (d_drain[i]) if (d_drain[i] != i % POY) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL basic_bank_order got_count=%0d exp_count=3", d_drain.size());
    end
    step(1'b0, 4, 3, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_busy_fall busy=%b done=%b exp=0,0", busy, done);
    end
  endtask

  task automatic test_latency();
    step(1'b1, 1, 1, 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL lat_pre rd_valid=%b wr_ready=%b exp=0,1", rd_valid, wr_ready);
    end
    step(1'b0, 1, 1, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || full_mask !== 3'b001) begin
      errors++; $display("FAIL lat_post rd_valid=%b mask=%b exp=1,001", rd_valid, full_mask);
    end
    for (int c = 0; c < 10 && m_phase != 0; c++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL lat_cyc%0d got=%h exp=%h", c, obs(), expv());
      end
      step(1'b0, 1, 1, 1'b0, 1'b1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL lat_timeout busy=%b exp=0", busy);
    end
  endtask

  task automatic test_simul();
    step(1'b1, 2, 2, 1'b0, 1'b0);
    step(1'b0, 2, 2, 1'b1, 1'b0);
    checks++;
    if (full_mask !== 3'b001) begin
      errors++; $display("FAIL simul_fill0 mask=%b exp=001", full_mask);
    end
    step(1'b0, 2, 2, 1'b0, 1'b1);
    checks++;
    if (rd_last !== 1'b1 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL simul_pre rd_last=%b wr_ready=%b exp=1,1", rd_last, wr_ready);
    end
    step(1'b0, 2, 2, 1'b1, 1'b1);
    checks++;
    if (full_mask !== 3'b010 || wr_bank !== 2'd2 || rd_bank !== 2'd1) begin
      errors++; $display("FAIL simul_both mask=%b wr_bank=%0d rd_bank=%0d exp=010,2,1",
                         full_mask, wr_bank, rd_bank);
    end
    for (int c = 0; c < 20 && m_phase != 0; c++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL simul_cyc%0d got=%h exp=%h", c, obs(), expv());
      end
      step(1'b0, 2, 2, 1'b0, 1'b1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL simul_timeout busy=%b exp=0", busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_obs();
    step(1'b1, 2, 7, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL bp_stall%0d got=%h exp=%h", c, obs(), expv());
      end
      step(1'b0, 2, 7, m_wr_ready(), 1'b0);
    end
    checks++;
    if (full_mask !== 3'b111 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full mask=%b wr_ready=%b exp=111,0", full_mask, wr_ready);
    end
    for (int c = 0; c < 200 && m_phase != 0; c++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL bp_drain%0d got=%h exp=%h", c, obs(), expv());
      end
      step(1'b0, 2, 7, m_wr_ready(), 1'b1);
    end
    ok = (d_drain.size() == 7) && (d_fill.size() == 7);
    foreach (d_drain[i]) if (d_drain[i] != i % POY) ok = 1'b0;
    foreach (d_fill[i]) if (d_fill[i] != i % POY) ok = 1'b0;
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++; $display("FAIL bp_order drains=%0d fills=%0d busy=%b exp=7,7,0",
                         d_drain.size(), d_fill.size(), busy);
    end
  endtask

  task automatic test_zero();
    step(1'b1, 3, 0, 1'b0, 1'b1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL zero_tiles done=%b busy=%b rd_valid=%b exp=1,1,0", done, busy, rd_valid);
    end
    step(1'b0, 3, 0, 1'b0, 1'b1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_tiles_end done=%b busy=%b exp=0,0", done, busy);
    end
    clear_obs();
    step(1'b1, 0, 2, 1'b0, 1'b1);
    for (int c = 0; c < 50 && m_phase != 0; c++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL zero_len_cyc%0d got=%h exp=%h", c, obs(), expv());
      end
      step(1'b0, 0, 2, m_wr_ready(), 1'b1);
    end
    checks++;
    if (d_hs !== 2 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_len handshakes=%0d busy=%b exp=2,0", d_hs, busy);
    end
  endtask

  task automatic test_err();
    logic [1:0] wb_before;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_pre err=%b exp=0", err);
    end
    wb_before = 2'(m_wcnt % POY);
    step(1'b0, 1, 1, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b1 || full_mask !== 3'b000 || wr_bank !== wb_before) begin
      errors++; $display("FAIL err_idle err=%b mask=%b wr_bank=%0d exp=1,000,%0d",
                         err, full_mask, wr_bank, wb_before);
    end
    step(1'b1, 1, 5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1, 5, 1'b1, 1'b0);
    checks++;
    if (full_mask !== 3'b111 || wr_ready !== 1'b0 || wr_bank !== 2'd0) begin
      errors++; $display("FAIL err_fill mask=%b wr_ready=%b wr_bank=%0d exp=111,0,0",
                         full_mask, wr_ready, wr_bank);
    end
    step(1'b0, 1, 5, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b1 || full_mask !== 3'b111 || wr_bank !== 2'd0) begin
      errors++; $display("FAIL err_full err=%b mask=%b wr_bank=%0d exp=1,111,0",
                         err, full_mask, wr_bank);
    end
    for (int c = 0; c < 50 && m_phase != 0; c++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL err_cyc%0d got=%h exp=%h", c, obs(), expv());
      end
      step(1'b0, 1, 5, m_wr_ready(), 1'b1);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL err_sticky err=%b busy=%b exp=1,0", err, busy);
    end
  endtask

  task automatic test_random();
    for (int l = 0; l < 6; l++) begin
      int len   = $urandom_range(0, 5);
      int tiles = $urandom_range(0, 8);
      int c     = 0;
      step(1'b1, len, tiles, 1'b0, 1'b0);
      while (m_phase != 0 && c < 400) begin
        checks++;
        if (obs() !== expv()) begin
          errors++; $display("FAIL rand_l%0d_c%0d got=%h exp=%h", l, c, obs(), expv());
        end
        step($urandom_range(0, 7) == 0, $urandom_range(0, 5), $urandom_range(0, 8),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        c++;
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL rand_timeout layer=%0d busy=%b exp=0", l, busy);
      end
    end
  endtask

  task automatic test_async_rst();
    step(1'b1, 4, 3, 1'b0, 1'b0);
    for (int c = 0; c < 30 && !(m_rd_valid() && m_addr == 2); c++) begin
      step(1'b0, 4, 3, m_wr_ready(), 1'b1);
    end
    checks++;
    if (rd_addr !== LW'(2) || rd_valid !== 1'b1) begin
      errors++; $display("FAIL arst_setup rd_addr=%0d rd_valid=%b exp=2,1", rd_addr, rd_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== OW'(0)) begin
      errors++; $display("FAIL arst_immediate got=%h exp=%h", obs(), OW'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL arst_release got=%h exp=%h", obs(), expv());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_obs();
    m_reset();
    test_reset();
    test_basic();
    test_latency();
    test_simul();
    test_backpressure();
    test_zero();
    test_err();
    test_random();
    test_async_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
